// File: rtl/inst_issue_queue.sv
// Circular instruction buffer between fetch and the master/slave decoders.
// Presents the two oldest entries and pops 0/1/2 per cycle based on decoder hazard feedback.
module inst_issue_queue #(
    parameter int DEPTH         = 16,
    parameter bit DUAL_ISSUE_EN = 1'b1,
    localparam int COUNT_W      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               issue_stall,
    input  logic [1:0]         in_valid,
    input  logic [31:0]        in_inst0,
    input  logic [31:0]        in_inst1,
    input  logic [31:0]        in_pc0,
    input  logic [31:0]        in_pc1,
    output logic               in_ready,
    output logic [31:0]        m_inst,
    output logic [31:0]        s_inst,
    output logic [31:0]        m_pc,
    output logic [31:0]        s_pc,
    output logic               m_present,
    output logic               s_present,
    input  logic               m_is_branch,
    input  logic               m_reg_wen,
    input  logic [4:0]         m_reg_waddr,
    input  logic               m_mem_en,
    input  logic               m_hilo,
    input  logic [4:0]         s_rs,
    input  logic [4:0]         s_rt,
    input  logic               s_is_branch,
    input  logic               s_mem_en,
    input  logic               s_hilo,
    input  logic               s_only_master,
    input  logic               s_spec_inst,
    output logic               m_issue,
    output logic               s_issue,
    output logic [COUNT_W-1:0] count
);
    localparam int PTR_W = COUNT_W - 1;

    logic [31:0]        inst_mem [DEPTH];
    logic [31:0]        pc_mem   [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0]   head_p1, tail_p1;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               push, raw_haz, slave_block;
    logic [1:0]         push_n, pop_n;

    assign head_p1   = head_q + PTR_W'(1);
    assign tail_p1   = tail_q + PTR_W'(1);
    assign count     = count_q;
    assign in_ready  = (count_q <= COUNT_W'(DEPTH - 2));
    assign m_present = (count_q != '0);
    assign s_present = (count_q >= COUNT_W'(2));

    assign m_inst = m_present ? inst_mem[head_q]  : 32'd0;
    assign m_pc   = m_present ? pc_mem[head_q]    : 32'd0;
    assign s_inst = s_present ? inst_mem[head_p1] : 32'd0;
    assign s_pc   = s_present ? pc_mem[head_p1]   : 32'd0;

    // A branch holds until its delay slot is in the queue so both leave together.
    assign m_issue = m_present & ~issue_stall & ~flush & ~(m_is_branch & ~s_present);

    assign raw_haz = m_reg_wen & (m_reg_waddr != 5'd0) &
                     ((m_reg_waddr == s_rs) | (m_reg_waddr == s_rt));
    assign slave_block = raw_haz | s_is_branch | s_only_master | s_spec_inst |
                         (m_mem_en & s_mem_en) | (m_hilo & s_hilo);
    assign s_issue = DUAL_ISSUE_EN & m_issue & s_present & ~slave_block;

    assign push   = in_ready & in_valid[0] & ~flush;
    assign push_n = push ? (in_valid[1] ? 2'd2 : 2'd1) : 2'd0;
    assign pop_n  = {1'b0, m_issue} + {1'b0, s_issue};

    always_comb begin
        head_d  = head_q + PTR_W'(pop_n);
        tail_d  = tail_q + PTR_W'(push_n);
        count_d = count_q + COUNT_W'(push_n) - COUNT_W'(pop_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail_q] <= in_inst0;
            pc_mem[tail_q]   <= in_pc0;
            if (in_valid[1]) begin
                inst_mem[tail_p1] <= in_inst1;
                pc_mem[tail_p1]   <= in_pc1;
            end
        end
    end
endmodule

// File: tb/tb_inst_issue_queue.sv
// Bench: dual-issue and single-issue instances on shared stimulus, checked against a queue model.
module tb_inst_issue_queue;
    localparam int D = 16;

    logic clk = 1'b0;
    logic resetn, flush, issue_stall;
    logic [1:0] in_valid;
    logic [31:0] in_inst0, in_inst1, in_pc0, in_pc1;
    logic m_is_branch, m_reg_wen, m_mem_en, m_hilo;
    logic [4:0] m_reg_waddr, s_rs, s_rt;
    logic s_is_branch, s_mem_en, s_hilo, s_only_master, s_spec_inst;
    logic [1:0] in_ready, m_present, s_present, m_issue, s_issue;
    logic [1:0][31:0] m_inst, s_inst, m_pc, s_pc;
    logic [1:0][4:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
    ent_t mq [2][$];
    bit exp_mi [2], exp_si [2], exp_rdy [2];

    always #5 clk = ~clk;

    inst_issue_queue #(.DEPTH(D), .DUAL_ISSUE_EN(1'b1)) u_dual (
        .clk(clk), .resetn(resetn), .flush(flush), .issue_stall(issue_stall),
        .in_valid(in_valid), .in_inst0(in_inst0), .in_inst1(in_inst1),
        .in_pc0(in_pc0), .in_pc1(in_pc1), .in_ready(in_ready[0]),
        .m_inst(m_inst[0]), .s_inst(s_inst[0]), .m_pc(m_pc[0]), .s_pc(s_pc[0]),
        .m_present(m_present[0]), .s_present(s_present[0]),
        .m_is_branch(m_is_branch), .m_reg_wen(m_reg_wen), .m_reg_waddr(m_reg_waddr),
        .m_mem_en(m_mem_en), .m_hilo(m_hilo), .s_rs(s_rs), .s_rt(s_rt),
        .s_is_branch(s_is_branch), .s_mem_en(s_mem_en), .s_hilo(s_hilo),
        .s_only_master(s_only_master), .s_spec_inst(s_spec_inst),
        .m_issue(m_issue[0]), .s_issue(s_issue[0]), .count(count[0]));

    inst_issue_queue #(.DEPTH(D), .DUAL_ISSUE_EN(1'b0)) u_single (
        .clk(clk), .resetn(resetn), .flush(flush), .issue_stall(issue_stall),
        .in_valid(in_valid), .in_inst0(in_inst0), .in_inst1(in_inst1),
        .in_pc0(in_pc0), .in_pc1(in_pc1), .in_ready(in_ready[1]),
        .m_inst(m_inst[1]), .s_inst(s_inst[1]), .m_pc(m_pc[1]), .s_pc(s_pc[1]),
        .m_present(m_present[1]), .s_present(s_present[1]),
        .m_is_branch(m_is_branch), .m_reg_wen(m_reg_wen), .m_reg_waddr(m_reg_waddr),
        .m_mem_en(m_mem_en), .m_hilo(m_hilo), .s_rs(s_rs), .s_rt(s_rt),
        .s_is_branch(s_is_branch), .s_mem_en(s_mem_en), .s_hilo(s_hilo),
        .s_only_master(s_only_master), .s_spec_inst(s_spec_inst),
        .m_issue(m_issue[1]), .s_issue(s_issue[1]), .count(count[1]));

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h want %0h", nm, k, act, exp);
        end
    endtask

    // The bench never drives the illegal fetch pattern; flag it if it ever appears.
    always @(posedge clk) begin
        if (resetn === 1'b1 && in_valid === 2'b10) begin
            n_bad++;
            $display("FAIL in_valid_illegal: got 10 want 00/01/11");
        end
    end

    task automatic idle();
        flush = 0; issue_stall = 0; in_valid = 2'b00;
        in_inst0 = 0; in_inst1 = 0; in_pc0 = 0; in_pc1 = 0;
        m_is_branch = 0; m_reg_wen = 0; m_reg_waddr = 0; m_mem_en = 0; m_hilo = 0;
        s_rs = 0; s_rt = 0; s_is_branch = 0; s_mem_en = 0; s_hilo = 0;
        s_only_master = 0; s_spec_inst = 0;
    endtask

    task automatic drive_push(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b);
        in_valid = v; in_inst0 = a; in_inst1 = b; in_pc0 = ~a; in_pc1 = ~b;
    endtask

    task automatic compare_one(input int k);
        int sz;
        bit mp, sp, haz, mi, si;
        logic [31:0] ei0, ep0, ei1, ep1;
        sz  = mq[k].size();
        mp  = sz >= 1;
        sp  = sz >= 2;
        ei0 = mp ? mq[k][0].inst : 32'd0;
        ep0 = mp ? mq[k][0].pc   : 32'd0;
        ei1 = sp ? mq[k][1].inst : 32'd0;
        ep1 = sp ? mq[k][1].pc   : 32'd0;
        haz = (m_reg_wen && m_reg_waddr != 0 && (m_reg_waddr == s_rs || m_reg_waddr == s_rt))
              || s_is_branch || s_only_master || s_spec_inst
              || (m_mem_en && s_mem_en) || (m_hilo && s_hilo);
        mi = mp && !issue_stall && !flush && !(m_is_branch && !sp);
        si = (k == 0) && mi && sp && !haz;
        exp_mi[k]  = mi;
        exp_si[k]  = si;
        exp_rdy[k] = (sz <= D - 2);
        chk("in_ready",  k, 64'(in_ready[k]),  64'(exp_rdy[k]));
        chk("m_present", k, 64'(m_present[k]), 64'(mp));
        chk("s_present", k, 64'(s_present[k]), 64'(sp));
        chk("m_issue",   k, 64'(m_issue[k]),   64'(mi));
        chk("s_issue",   k, 64'(s_issue[k]),   64'(si));
        chk("count",     k, 64'(count[k]),     64'(sz));
        chk("m_inst",    k, 64'(m_inst[k]),    64'(ei0));
        chk("m_pc",      k, 64'(m_pc[k]),      64'(ep0));
        chk("s_inst",    k, 64'(s_inst[k]),    64'(ei1));
        chk("s_pc",      k, 64'(s_pc[k]),      64'(ep1));
    endtask

    // Compare both DUTs with the model, then advance the model across the clock edge.
    task automatic check_cycle();
        #1;
        compare_one(0);
        compare_one(1);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (flush) mq[k].delete();
            else begin
                repeat (int'(exp_mi[k]) + int'(exp_si[k])) void'(mq[k].pop_front());
                if (exp_rdy[k] && in_valid[0]) begin
                    mq[k].push_back('{in_inst0, in_pc0});
                    if (in_valid[1]) mq[k].push_back('{in_inst1, in_pc1});
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        resetn = 0;
        #1;
        mq[0].delete();
        mq[1].delete();
        #2;
        resetn = 1;
    endtask

    typedef struct {
        int n; bit stall, fl, mbr, mwen; bit [4:0] mwa, srs, srt;
        bit mmem, smem, mhilo, shilo, sbr, som, sspec, exm, exs;
    } vec_t;
    vec_t vt [17];

    initial begin
        int idx;
        int r;
        // n  stl fl mbr wen mwa srs srt mmem smem mhl shl sbr som spc  exm exs
        vt[0]  = '{2, 0, 0, 0, 1, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[1]  = '{2, 0, 0, 0, 1, 3, 3, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        vt[2]  = '{2, 0, 0, 0, 1, 3, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        vt[3]  = '{2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[4]  = '{2, 0, 0, 0, 0, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[5]  = '{2, 0, 0, 0, 1, 3, 1, 2, 0, 0, 0, 0, 1, 0, 0, 1, 0};
        vt[6]  = '{2, 0, 0, 0, 1, 3, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        vt[7]  = '{2, 0, 0, 0, 1, 3, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        vt[8]  = '{2, 0, 0, 0, 1, 3, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0};
        vt[9]  = '{2, 0, 0, 0, 1, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[10] = '{2, 0, 0, 0, 1, 3, 1, 2, 0, 0, 1, 1, 0, 0, 0, 1, 0};
        vt[11] = '{2, 0, 0, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[12] = '{1, 0, 0, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[13] = '{1, 0, 0, 0, 1, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        vt[14] = '{2, 1, 0, 0, 1, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[15] = '{2, 0, 1, 0, 1, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[16] = '{0, 0, 0, 0, 1, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        // Reset state
        idle();
        resetn = 0;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_count",     k, 64'(count[k]),     64'd0);
            chk("rst_m_present", k, 64'(m_present[k]), 64'd0);
            chk("rst_m_issue",   k, 64'(m_issue[k]),   64'd0);
            chk("rst_m_inst",    k, 64'(m_inst[k]),    64'd0);
            chk("rst_s_inst",    k, 64'(s_inst[k]),    64'd0);
        end
        resetn = 1;

        // Issue-decision table on a queue primed under stall
        for (int i = 0; i < 17; i++) begin
            do_reset();
            if (vt[i].n > 0) begin
                @(negedge clk);
                idle();
                issue_stall = 1;
                drive_push((vt[i].n == 2) ? 2'b11 : 2'b01, 32'h100 + 32'(i), 32'h200 + 32'(i));
                check_cycle();
            end
            @(negedge clk);
            idle();
            issue_stall = vt[i].stall; flush = vt[i].fl; m_is_branch = vt[i].mbr;
            m_reg_wen = vt[i].mwen; m_reg_waddr = vt[i].mwa; s_rs = vt[i].srs; s_rt = vt[i].srt;
            m_mem_en = vt[i].mmem; s_mem_en = vt[i].smem; m_hilo = vt[i].mhilo; s_hilo = vt[i].shilo;
            s_is_branch = vt[i].sbr; s_only_master = vt[i].som; s_spec_inst = vt[i].sspec;
            #1;
            chk($sformatf("vec%0d_m_issue", i), 0, 64'(m_issue[0]), 64'(vt[i].exm));
            chk($sformatf("vec%0d_s_issue", i), 0, 64'(s_issue[0]), 64'(vt[i].exs));
            chk($sformatf("vec%0d_m_issue", i), 1, 64'(m_issue[1]), 64'(vt[i].exm));
            chk($sformatf("vec%0d_s_issue", i), 1, 64'(s_issue[1]), 64'd0);
            check_cycle();
        end

        // Branch waits for its delay slot
        do_reset();
        @(negedge clk); idle(); drive_push(2'b01, 32'h1000_0001, 32'h0); check_cycle();
        repeat (2) begin
            @(negedge clk); idle(); m_is_branch = 1;
            #1; chk("beq_wait", 0, 64'(m_issue[0]), 64'd0);
            check_cycle();
        end
        @(negedge clk); idle(); m_is_branch = 1; drive_push(2'b01, 32'h2000_0002, 32'h0);
        #1; chk("beq_wait_push", 0, 64'(m_issue[0]), 64'd0);
        check_cycle();
        @(negedge clk); idle(); m_is_branch = 1;
        #1;
        chk("beq_m_issue", 0, 64'(m_issue[0]), 64'd1);
        chk("beq_s_issue", 0, 64'(s_issue[0]), 64'd1);
        chk("beq_s_inst",  0, 64'(s_inst[0]),  64'h2000_0002);
        chk("beq_m_issue", 1, 64'(m_issue[1]), 64'd1);
        chk("beq_s_issue", 1, 64'(s_issue[1]), 64'd0);
        check_cycle();

        // Fill across the wrap point under stall, then drain in order
        do_reset();
        @(negedge clk); idle(); drive_push(2'b11, 32'h1, 32'h2); check_cycle();
        @(negedge clk); idle(); drive_push(2'b01, 32'h3, 32'h0); check_cycle();
        repeat (4) begin @(negedge clk); idle(); check_cycle(); end
        for (int c = 0; c < 7; c++) begin
            @(negedge clk); idle(); issue_stall = 1;
            drive_push(2'b11, 32'h1000 + 32'(2*c), 32'h1000 + 32'(2*c+1));
            check_cycle();
        end
        @(negedge clk); idle(); issue_stall = 1; drive_push(2'b01, 32'h100E, 32'h0); check_cycle();
        @(negedge clk); idle(); issue_stall = 1;
        #1;
        chk("full_count",    0, 64'(count[0]),    64'd15);
        chk("full_in_ready", 0, 64'(in_ready[0]), 64'd0);
        check_cycle();
        idx = 0;
        repeat (10) begin
            @(negedge clk); idle();
            #1;
            if (m_issue[0]) begin chk("wrap_order_m", 0, 64'(m_inst[0]), 64'(32'h1000 + 32'(idx))); idx++; end
            if (s_issue[0]) begin chk("wrap_order_s", 0, 64'(s_inst[0]), 64'(32'h1000 + 32'(idx))); idx++; end
            check_cycle();
        end
        chk("wrap_drained", 0, 64'(idx), 64'd15);

        // Flush at count 9 with a simultaneous push
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); idle(); issue_stall = 1;
            drive_push((c < 4) ? 2'b11 : 2'b01, 32'h3000 + 32'(c), 32'h3100 + 32'(c));
            check_cycle();
        end
        @(negedge clk); idle(); flush = 1; drive_push(2'b11, 32'h4000, 32'h4001);
        #1; chk("pre_flush_count", 0, 64'(count[0]), 64'd9);
        check_cycle();
        @(negedge clk); idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("flush_count",     k, 64'(count[k]),     64'd0);
            chk("flush_m_present", k, 64'(m_present[k]), 64'd0);
            chk("flush_m_inst",    k, 64'(m_inst[k]),    64'd0);
        end
        check_cycle();

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            r = $urandom_range(0, 2);
            drive_push((r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11, $urandom, $urandom);
            flush = ($urandom_range(0, 15) == 0);
            issue_stall = ($urandom_range(0, 7) == 0);
            m_is_branch = ($urandom_range(0, 5) == 0);
            m_reg_wen = $urandom_range(0, 1);
            m_reg_waddr = 5'($urandom_range(0, 3));
            s_rs = 5'($urandom_range(0, 3));
            s_rt = 5'($urandom_range(0, 3));
            m_mem_en = ($urandom_range(0, 3) == 0);
            s_mem_en = ($urandom_range(0, 3) == 0);
            m_hilo = ($urandom_range(0, 3) == 0);
            s_hilo = ($urandom_range(0, 3) == 0);
            s_is_branch = ($urandom_range(0, 7) == 0);
            s_only_master = ($urandom_range(0, 7) == 0);
            s_spec_inst = ($urandom_range(0, 7) == 0);
            check_cycle();
        end

        // Single-issue drain of 4 independent instructions, then async reset mid-run
        do_reset();
        @(negedge clk); idle(); drive_push(2'b11, 32'h5000, 32'h5001); check_cycle();
        @(negedge clk); idle(); drive_push(2'b11, 32'h5002, 32'h5003);
        #1; chk("single_s_issue", 1, 64'(s_issue[1]), 64'd0);
        check_cycle();
        @(negedge clk); idle();
        #1; chk("single_s_issue", 1, 64'(s_issue[1]), 64'd0);
        check_cycle();
        @(negedge clk); idle();
        #1; chk("single_count_mid", 1, 64'(count[1]), 64'd2);
        #1; resetn = 0;
        #1;
        chk("async_rst_count", 1, 64'(count[1]), 64'd0);
        chk("async_rst_m_present", 1, 64'(m_present[1]), 64'd0);
        mq[0].delete();
        mq[1].delete();
        #1; resetn = 1;
        @(negedge clk); idle(); check_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
